// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: reset PC default,
// instruction bus type, FSM encoding and PC alignment helper.
package if_stage_pkg;

    // Default PC loaded on reset.
    localparam logic [63:0] PC_RESET = 64'h8000_0000;

    // Instruction bus width and type.
    localparam int INST_W = 32;
    typedef logic [INST_W-1:0] inst_t;

    // Fetch FSM encoding.
    typedef enum logic [1:0] {
        IF_ST_REQ  = 2'd0,
        IF_ST_WAIT = 2'd1,
        IF_ST_HOLD = 2'd2
    } if_state_e;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [63:0] align_pc(input logic [63:0] addr);
        return addr & ~64'd3;
    endfunction

endpackage

// File: rtl/if_perf_cnt.sv
// Fetch performance counters: completed handoffs and dropped instructions.
// Only instantiated when IF_PERF_EN is defined. Both counters wrap.
module if_perf_cnt
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        kill_inc,
    output logic [63:0] fetch_cnt,
    output logic [31:0] kill_cnt
);

    logic [63:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] kill_cnt_q, kill_cnt_d;

    // Next-count computation; increments wrap naturally.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        if (fetch_inc) begin
            fetch_cnt_d = fetch_cnt_q + 64'd1;
        end
        if (kill_inc) begin
            kill_cnt_d = kill_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= 64'd0;
            kill_cnt_q  <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign kill_cnt  = kill_cnt_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: holds the PC, issues one imem request at a time,
// captures the response and offers it to decode over valid/ready.
// Optional feature macro: IF_PERF_EN adds perf_fetch_cnt / perf_kill_cnt.
//
// Handshakes: a transfer happens in a cycle where both valid and ready are
// high. imem_req_valid is not sticky: the request address may change while
// unaccepted (on redirect). inst_valid may drop without a transfer when a
// redirect arrives in the same cycle.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = PC_RESET
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output inst_t       inst,
    output logic [63:0] inst_addr,
    input  logic        id_ready,
`ifdef IF_PERF_EN
    output logic [63:0] perf_fetch_cnt,
    output logic [31:0] perf_kill_cnt,
`endif
    output if_state_e   dbg_state
);

    if_state_e   state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] req_addr_q, req_addr_d;
    logic        kill_q, kill_d;
    inst_t       inst_q, inst_d;
    logic [63:0] inst_addr_q, inst_addr_d;
    logic [63:0] redirect_tgt;

    assign redirect_tgt = align_pc(redirect_pc);

    // Next-state and datapath update for the REQ/WAIT/HOLD fetch FSM.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        kill_d      = kill_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        case (state_q)
            IF_ST_REQ: begin
                // Responses are ignored here: any stray one belongs to a
                // request issued before a reset.
                if (imem_req_ready) begin
                    req_addr_d = pc_q;
                    state_d    = IF_ST_WAIT;
                    if (redirect_valid) begin
                        // The accepted request is already wrong-path.
                        kill_d = 1'b1;
                        pc_d   = redirect_tgt;
                    end
                end else if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
            end
            IF_ST_WAIT: begin
                if (imem_resp_valid) begin
                    if (kill_q || redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = IF_ST_REQ;
                        if (redirect_valid) begin
                            pc_d = redirect_tgt;
                        end
                    end else begin
                        inst_d      = imem_resp_data;
                        inst_addr_d = req_addr_q;
                        pc_d        = req_addr_q + 64'd4;
                        state_d     = IF_ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    // Outstanding response must be discarded when it lands.
                    kill_d = 1'b1;
                    pc_d   = redirect_tgt;
                end
            end
            IF_ST_HOLD: begin
                // Redirect has priority over a decode handoff.
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = IF_ST_REQ;
                end else if (id_ready) begin
                    state_d = IF_ST_REQ;
                end
            end
            default: begin
                state_d = IF_ST_REQ;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IF_ST_REQ;
            pc_q        <= RESET_PC;
            req_addr_q  <= 64'd0;
            kill_q      <= 1'b0;
            inst_q      <= '0;
            inst_addr_q <= 64'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            kill_q      <= kill_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
        end
    end

    // The FSM sits in REQ during reset, so the request is masked by rst.
    assign imem_req_valid = (state_q == IF_ST_REQ) && !rst;
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == IF_ST_HOLD) && !redirect_valid;
    assign inst           = inst_q;
    assign inst_addr      = inst_addr_q;
    assign dbg_state      = state_q;

`ifdef IF_PERF_EN
    logic fetch_inc;
    logic kill_inc;

    assign fetch_inc = inst_valid && id_ready;
    assign kill_inc  = ((state_q == IF_ST_WAIT) && imem_resp_valid && (kill_q || redirect_valid))
                     || ((state_q == IF_ST_HOLD) && redirect_valid);

    if_perf_cnt u_perf (
        .clk       (clk),
        .rst       (rst),
        .fetch_inc (fetch_inc),
        .kill_inc  (kill_inc),
        .fetch_cnt (perf_fetch_cnt),
        .kill_cnt  (perf_kill_cnt)
    );
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. Two instances share all inputs: dut uses the
// default reset PC, dut_w uses 64'hFFFF_FFFF_FFFF_FFFC to exercise PC wrap.
// Their FSMs follow identical state trajectories since control does not
// depend on addresses.
module tb_if_stage;
  import if_stage_pkg::*;

  typedef struct packed {
    logic [7:0]  gap;
    logic [63:0] addr;
    logic [31:0] inst;
  } ho_t;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_ready;

  logic        imem_req_valid, w_req_valid;
  logic [63:0] imem_req_addr, w_req_addr;
  logic        inst_valid, w_inst_valid;
  logic [31:0] inst, w_inst;
  logic [63:0] inst_addr, w_inst_addr;
  if_state_e   dbg_state, w_dbg_state;
`ifdef IF_PERF_EN
  logic [63:0] perf_fetch_cnt, w_perf_fetch_cnt;
  logic [31:0] perf_kill_cnt, w_perf_kill_cnt;
`endif

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_addr       (inst_addr),
    .id_ready        (id_ready),
`ifdef IF_PERF_EN
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_kill_cnt   (perf_kill_cnt),
`endif
    .dbg_state       (dbg_state)
  );

  if_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (w_req_valid),
    .imem_req_addr   (w_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (w_inst_valid),
    .inst            (w_inst),
    .inst_addr       (w_inst_addr),
    .id_ready        (id_ready),
`ifdef IF_PERF_EN
    .perf_fetch_cnt  (w_perf_fetch_cnt),
    .perf_kill_cnt   (w_perf_kill_cnt),
`endif
    .dbg_state       (w_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_req_q[$];
  logic [63:0] exp_w_q[$];
  ho_t         exp_ho_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_ho = 0;
  logic        wrap_chk = 1'b0;
  logic        tb_done = 1'b0;
  int          mem_lat = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event with value %h (cycle %0d)", name, act, cyc);
  endtask

  // ---------------- instruction memory ----------------
  // Responds mem_lat cycles after each accepted request with addr+0x13.
  initial begin : imem
    logic        mem_pend;
    logic [63:0] mem_addr;
    int          mem_cnt;
    mem_pend = 1'b0;
    mem_addr = 64'd0;
    mem_cnt  = 0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (mem_pend) begin
        if (mem_cnt <= 1) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_addr[31:0] + 32'h13;
          mem_pend        = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        mem_pend = 1'b1;
        mem_addr = imem_req_addr;
        mem_cnt  = mem_lat;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ho(input logic [63:0] a, input logic [31:0] d, input int gap);
    ho_t e;
    e.addr = a;
    e.inst = d;
    e.gap  = 8'(gap);
    exp_ho_q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    check({tag, "_req_addr"}, imem_req_addr, 64'h8000_0000);
    check({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
    check({tag, "_inst"}, 64'(inst), 64'd0);
    check({tag, "_inst_addr"}, inst_addr, 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
    check({tag, "_w_req_valid"}, 64'(w_req_valid), 64'd0);
    check({tag, "_w_req_addr"}, w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check({tag, "_w_inst_valid"}, 64'(w_inst_valid), 64'd0);
    check({tag, "_w_inst"}, 64'(w_inst), 64'd0);
    check({tag, "_w_inst_addr"}, w_inst_addr, 64'd0);
    check({tag, "_w_state"}, 64'(w_dbg_state), 64'd0);
`ifdef IF_PERF_EN
    check({tag, "_perf_fetch"}, perf_fetch_cnt, 64'd0);
    check({tag, "_perf_kill"}, 64'(perf_kill_cnt), 64'd0);
`endif
  endtask

  // ---------------- monitor ----------------
  task automatic monitor();
    ho_t e;
    while (!tb_done) begin
      @(negedge clk);
      if (!rst) begin
        if (imem_req_valid && imem_req_ready) begin
          if (exp_req_q.size() == 0) unexpected("req", imem_req_addr);
          else check("req_addr", imem_req_addr, exp_req_q.pop_front());
        end
        if (wrap_chk && w_req_valid && imem_req_ready) begin
          if (exp_w_q.size() == 0) unexpected("w_req", w_req_addr);
          else check("w_req_addr", w_req_addr, exp_w_q.pop_front());
        end
        if (inst_valid && id_ready) begin
          if (exp_ho_q.size() == 0) begin
            unexpected("handoff", inst_addr);
          end else begin
            e = exp_ho_q.pop_front();
            check("ho_addr", inst_addr, e.addr);
            check("ho_inst", 64'(inst), 64'(e.inst));
            if (e.gap != 8'd0) check("ho_gap", 64'(cyc - last_ho), 64'(e.gap));
          end
          last_ho = cyc;
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic stimulus();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    tick(2);
    check_reset("init");

    // Straight-line fetch, 1-cycle memory: handoffs every 3 cycles.
    exp_req_q.push_back(64'h8000_0000);
    exp_req_q.push_back(64'h8000_0004);
    exp_req_q.push_back(64'h8000_0008);
    exp_req_q.push_back(64'h8000_000C);
    exp_w_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_w_q.push_back(64'h0);
    exp_w_q.push_back(64'h4);
    exp_w_q.push_back(64'h8);
    push_ho(64'h8000_0000, 32'h8000_0013, 0);
    push_ho(64'h8000_0004, 32'h8000_0017, 3);
    push_ho(64'h8000_0008, 32'h8000_001B, 3);
    wrap_chk = 1'b1;
    tick(1);
    rst = 1'b0;                                    // cycle 0
    tick(9);                                       // cycle 9: 4th request
    id_ready = 1'b0;
    tick(1);                                       // cycle 10
    wrap_chk = 1'b0;
    tick(1);                                       // cycle 11: HOLD stalls
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(inst_valid), 64'd1);
      check("stall_inst", 64'(inst), 64'h8000_001F);
      check("stall_addr", inst_addr, 64'h8000_000C);
      check("stall_noreq", 64'(imem_req_valid), 64'd0);
      tick(1);
    end
    // cycle 16: release the stall, then redirect at the next handshake.
    push_ho(64'h8000_000C, 32'h8000_001F, 0);
    exp_req_q.push_back(64'h8000_0010);
    exp_req_q.push_back(64'h8000_0200);
    id_ready = 1'b1;
    tick(1);                                       // cycle 17
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0201;
    tick(1);                                       // cycle 18: resp dropped
    redirect_valid = 1'b0;
    tick(1);                                       // cycle 19
    mem_lat = 2;
    exp_req_q.push_back(64'h8000_0100);
    tick(1);                                       // cycle 20: WAIT redirect
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    tick(1);                                       // cycle 21: resp dropped
    redirect_valid = 1'b0;
    mem_lat = 1;
    tick(3);                                       // cycle 24: HOLD 0x100
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    #1;
    check("redir_hold_valid", 64'(inst_valid), 64'd0);
    check("redir_hold_addr", inst_addr, 64'h8000_0100);
    check("redir_hold_inst", 64'(inst), 64'h8000_0113);
    exp_req_q.push_back(64'h8000_0300);
    exp_req_q.push_back(64'h8000_0304);
    push_ho(64'h8000_0300, 32'h8000_0313, 0);
    tick(1);                                       // cycle 25
    redirect_valid = 1'b0;
    tick(3);                                       // cycle 28: req 0x304
`ifdef IF_PERF_EN
    check("perf_fetch_mid", perf_fetch_cnt, 64'd5);
    check("perf_kill_mid", 64'(perf_kill_cnt), 64'd3);
`endif
    mem_lat = 2;
    tick(1);                                       // cycle 29: WAIT, reset
    mem_lat = 1;
    rst = 1'b1;
    #1;
    check_reset("midrst");
    exp_req_q.push_back(64'h8000_0000);
    exp_req_q.push_back(64'h8000_0004);
    exp_w_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_w_q.push_back(64'h0);
    push_ho(64'h8000_0000, 32'h8000_0013, 0);
    push_ho(64'h8000_0004, 32'h8000_0017, 3);
    wrap_chk = 1'b1;
    tick(1);                                       // cycle 30: stray resp
    rst = 1'b0;
    tick(5);                                       // cycle 35
    imem_req_ready = 1'b0;
    tick(4);
    wrap_chk = 1'b0;
`ifdef IF_PERF_EN
    check("perf_fetch_end", perf_fetch_cnt, 64'd2);
    check("perf_kill_end", 64'(perf_kill_cnt), 64'd0);
`endif
    tb_done = 1'b1;
  endtask

  // ---------------- run and report ----------------
  initial begin
    fork
      monitor();
      stimulus();
    join
    check("req_q_left", 64'(exp_req_q.size()), 64'd0);
    check("w_q_left", 64'(exp_w_q.size()), 64'd0);
    check("ho_q_left", 64'(exp_ho_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
